// File: rtl/imm_extend_unit.sv
// Immediate-extension unit: extends an IN_W-bit immediate to OUT_W bits by mode
// and queues the results in a 2-entry FIFO with valid/ready on both sides.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  input_data,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] output_data,
  output logic [1:0]       count
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] ext_value;
  logic [OUT_W-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  // Upper placement is the zero-extended value shifted by PAD; the shift
  // truncates naturally when OUT_W < 2*IN_W.
  always_comb begin
    ext_zero = {{PAD{1'b0}}, input_data};
    ext_sign = {{PAD{input_data[IN_W-1]}}, input_data};
    case (mode)
      2'b00:   ext_value = ext_zero;
      2'b01:   ext_value = ext_sign;
      2'b10:   ext_value = ext_zero << PAD;
      default: ext_value = ext_sign << 2;
    endcase
  end

  assign in_ready    = (count_q != 2'd2);
  assign out_valid   = (count_q != 2'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign count       = count_q;
  assign output_data = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ext_value;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Bench for imm_extend_unit: directed scenarios then random traffic, all checked
// against a queue-based reference model using plain arithmetic extension.
module tb_imm_extend_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] input_data;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] output_data;
  logic [1:0]  count;

  int n_checks;
  int n_errors;
  logic [31:0] model_q[$];

  imm_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .input_data(input_data),
    .mode(mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .output_data(output_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
    longint s;
    s = (d >= 16'h8000) ? longint'(d) - 65536 : longint'(d);
    case (m)
      2'd0:    return 32'(longint'(d));
      2'd1:    return 32'(s);
      2'd2:    return 32'(longint'(d) * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic check_state();
    int n;
    n = model_q.size();
    chk("count", 32'(count), 32'(n));
    chk("out_valid", 32'(out_valid), (n != 0) ? 32'd1 : 32'd0);
    chk("in_ready", 32'(in_ready), (n != 2) ? 32'd1 : 32'd0);
    chk("output_data", output_data, (n != 0) ? model_q[0] : 32'd0);
  endtask

  // Called at a falling edge: drive inputs, advance one clock, check at next fall.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [1:0] m, input logic r);
    logic do_push;
    logic do_pop;
    logic [31:0] e;
    in_valid   = v;
    input_data = d;
    mode       = m;
    out_ready  = r;
    do_push = v && (model_q.size() != 2);
    do_pop  = r && (model_q.size() != 0);
    e = ref_ext(d, m);
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(e);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    input_data = '0;
    mode       = '0;
    out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_output_data", output_data, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // zero extension, single push with consumer ready
    cycle(1'b1, 16'hFFFF, 2'd0, 1'b1);
    chk("m0_ffff", output_data, 32'h0000FFFF);
    chk("m0_count", 32'(count), 32'd1);
    cycle(1'b0, 16'h0000, 2'd0, 1'b1);
    chk("m0_drain", 32'(count), 32'd0);

    // sign extension back-to-back: push+pop at count 1
    cycle(1'b1, 16'hFFFF, 2'd1, 1'b1);
    chk("m1_ffff", output_data, 32'hFFFFFFFF);
    cycle(1'b1, 16'h7FFF, 2'd1, 1'b1);
    chk("m1_7fff", output_data, 32'h00007FFF);
    chk("m1_count", 32'(count), 32'd1);
    cycle(1'b1, 16'h1234, 2'd2, 1'b1);
    chk("m2_1234", output_data, 32'h12340000);
    cycle(1'b1, 16'hFFFE, 2'd3, 1'b1);
    chk("m3_fffe", output_data, 32'hFFFFFFF8);
    cycle(1'b1, 16'h0003, 2'd3, 1'b1);
    chk("m3_0003", output_data, 32'h0000000C);
    cycle(1'b0, 16'h0000, 2'd0, 1'b1);

    // backpressure: fill, ignored third push, drain in order
    cycle(1'b1, 16'h0001, 2'd0, 1'b0);
    cycle(1'b1, 16'h8000, 2'd1, 1'b0);
    chk("bp_count", 32'(count), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h5555, 2'd0, 1'b0);
    chk("bp_third_ignored", 32'(count), 32'd2);
    chk("bp_head0", output_data, 32'h00000001);
    cycle(1'b0, 16'h0000, 2'd0, 1'b1);
    chk("bp_head1", output_data, 32'hFFFF8000);
    cycle(1'b0, 16'h0000, 2'd0, 1'b1);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // asynchronous reset mid-cycle while full
    cycle(1'b1, 16'hAAAA, 2'd0, 1'b0);
    cycle(1'b1, 16'hBBBB, 2'd1, 1'b0);
    chk("ar_full", 32'(count), 32'd2);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_output_data", output_data, 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    model_q.delete();
    #1 reset = 1'b0;
    @(negedge clk);
    cycle(1'b1, 16'h8001, 2'd2, 1'b0);
    chk("ar_repush", output_data, 32'h80010000);
    chk("ar_repush_count", 32'(count), 32'd1);
    cycle(1'b0, 16'h0000, 2'd0, 1'b1);

    // random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, buffered immediate-extension unit for the multicycle datapath. Accepts an IN_W-bit immediate with a mode code, produces an OUT_W-bit zero-extended, sign-extended, upper-placed or word-offset value, and holds results in a 2-entry output buffer with valid/ready handshakes on both sides. Sits between instruction decode and the ALU-B / PC-offset operand muxes. Decode can run ahead by one immediate while the execute stage stalls.

## Interface
- IN_W, default 16: input immediate width.
- OUT_W, default 32: output width; legal only when OUT_W >= IN_W + 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  immediate and mode valid this cycle.
- in_ready  output  1  buffer can accept; equals (count != 2).
- input_data  input  IN_W  raw immediate.
- mode  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 sign then <<2.
- out_valid  output  1  head entry valid; equals (count != 0).
- out_ready  input  1  consumer takes head this cycle.
- output_data  output  OUT_W  head entry value; 0 when empty.
- count  output  2  occupancy, 0..2.

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Extension is computed on push and stored in the buffer. The mode is not stored.
  - 00: {(OUT_W-IN_W) zeros, input_data}.
  - 01: {(OUT_W-IN_W) copies of input_data[IN_W-1], input_data}.
  - 10: {input_data, (OUT_W-IN_W) zeros} when OUT_W >= 2*IN_W. Otherwise input_data << (OUT_W-IN_W), truncated to OUT_W.
  - 11: (sign-extended value) << 2, truncated to OUT_W. The two LSBs are zero.
- Buffer is a 2-entry FIFO: head register plus one slot, or a 2-entry ring with 1-bit read/write pointers.
- Ordering is strictly first-in first-out.
- Push only at count 0: count becomes 1, and the entry becomes the head.
- Pop only: count decrements. At count 2, the second entry becomes the head.
- Push and pop together at count 1: count stays 1. The new entry is the head next cycle.
- Push and pop together at count 2 cannot occur, because in_ready is 0. Pop only applies.
- Push while empty with out_ready high: the entry becomes visible next cycle. There is no same-cycle bypass.
- in_valid while in_ready is 0: no state change. The producer must hold input_data and mode stable.
- Reset, including mid-operation: the buffer is emptied and contents are discarded. Entries are not flushed to the output.

## Timing
- Reset values:
  - count = 0, out_valid = 0, output_data = 0, in_ready = 1.
  - Storage registers = 0.
- Latency: 1 cycle from accepting edge to out_valid = 1 with the result on output_data.
- Throughput: 1 immediate per cycle when out_ready is held high.
- in_ready and out_valid are pure functions of registered count. There is no combinational path from in_valid or out_ready to any output.
- output_data is driven from a register or a mux over registers selected by the read pointer. No extension logic sits on the output path.
- All state updates occur on the rising clk edge. Reset takes effect immediately and asynchronously, not waiting for an edge.

## Test plan
- Mode 00, input_data = 16'hFFFF, out_ready = 1 -> next cycle out_valid = 1, output_data = 32'h0000FFFF, count = 1, then count returns to 0.
- Mode 01 with 16'hFFFF, then 16'h7FFF, back-to-back -> outputs 32'hFFFFFFFF then 32'h00007FFF, on consecutive cycles.
- Mode 10 with 16'h1234 -> 32'h12340000. Mode 11 with 16'hFFFE -> 32'hFFFFFFF8. Mode 11 with 16'h0003 -> 32'h0000000C.
- Backpressure:
  - Hold out_ready = 0 and push 16'h0001 (mode 00), then 16'h8000 (mode 01) -> count = 2, in_ready = 0.
  - A third push is ignored.
  - Release out_ready -> 32'h00000001 then 32'hFFFF8000, in order.
- Simultaneous push and pop at count 1 -> count stays 1, and the head updates to the new value on the following cycle.
- Assert reset asynchronously mid-cycle at count = 2 -> out_valid, count and output_data go to 0 without waiting for a clock edge, and in_ready = 1. The next push after release behaves as from empty.
